// File: rtl/pht_update_ctrl.sv
// Port-B owner of the branch predictor PHT: sweeps the table to INIT_VAL after reset
// or clear, then applies saturating-counter read-modify-write updates from commit.
module pht_update_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 2,
  parameter int unsigned INIT_VAL   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  upd_valid_i,
  output logic                  upd_ready_o,
  input  logic [ADDR_WIDTH-1:0] upd_addr_i,
  input  logic                  upd_taken_i,
  input  logic                  clear_i,
  output logic                  init_done_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [CNT_WIDTH-1:0]  ram_wdata_o,
  input  logic [CNT_WIDTH-1:0]  ram_rdata_i,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_IDLE   = 2'd1,
    S_WRBACK = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] IDX_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  INIT_CNT = CNT_WIDTH'(INIT_VAL);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_idx;
  logic                  r_clr_pend;
  logic [ADDR_WIDTH-1:0] r_upd_addr;
  logic                  r_upd_taken;

  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_clr_idx_nxt;
  logic                  w_clr_pend_nxt;
  logic                  w_accept;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;

  // Saturating counter step on the old value returned by the read issued in IDLE.
  always_comb begin
    w_cnt_nxt = ram_rdata_i;
    if (r_upd_taken) begin
      if (ram_rdata_i != CNT_MAX) w_cnt_nxt = ram_rdata_i + CNT_ONE;
    end else begin
      if (ram_rdata_i != '0) w_cnt_nxt = ram_rdata_i - CNT_ONE;
    end
  end

  // Handshake: an update is accepted in the cycle where upd_valid_i and upd_ready_o
  // are both high; the requester must hold addr/taken stable until then.
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_idx_nxt  = r_clr_idx;
    w_clr_pend_nxt = r_clr_pend;
    w_accept       = 1'b0;
    upd_ready_o    = 1'b0;
    init_done_o    = 1'b0;
    ram_en_o       = 1'b0;
    ram_we_o       = 1'b0;
    ram_addr_o     = '0;
    ram_wdata_o    = '0;

    case (r_state)
      S_CLEAR: begin
        ram_en_o    = 1'b1;
        ram_we_o    = 1'b1;
        ram_addr_o  = r_clr_idx;
        ram_wdata_o = INIT_CNT;
        if (r_clr_idx == IDX_LAST) begin
          w_clr_idx_nxt  = '0;
          w_clr_pend_nxt = 1'b0;
          // A clear seen after index 0 restarts the sweep without an IDLE gap.
          w_state_nxt    = (r_clr_pend || clear_i) ? S_CLEAR : S_IDLE;
        end else begin
          w_clr_idx_nxt = r_clr_idx + IDX_ONE;
          if (clear_i && (r_clr_idx != '0)) w_clr_pend_nxt = 1'b1;
        end
      end

      S_IDLE: begin
        init_done_o = 1'b1;
        upd_ready_o = ~r_clr_pend & ~clear_i;
        if (r_clr_pend || clear_i) begin
          w_state_nxt = S_CLEAR;
        end else if (upd_valid_i) begin
          ram_en_o    = 1'b1;
          ram_addr_o  = upd_addr_i;
          w_accept    = 1'b1;
          w_state_nxt = S_WRBACK;
        end
      end

      S_WRBACK: begin
        init_done_o = 1'b1;
        ram_en_o    = 1'b1;
        ram_we_o    = 1'b1;
        ram_addr_o  = r_upd_addr;
        ram_wdata_o = w_cnt_nxt;
        w_state_nxt = (r_clr_pend || clear_i) ? S_CLEAR : S_IDLE;
      end

      default: begin
        w_state_nxt = S_CLEAR;
      end
    endcase

    if (rst) begin
      upd_ready_o = 1'b0;
      init_done_o = 1'b0;
      ram_en_o    = 1'b0;
      ram_we_o    = 1'b0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_CLEAR;
      r_clr_idx   <= '0;
      r_clr_pend  <= 1'b0;
      r_upd_addr  <= '0;
      r_upd_taken <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_idx  <= w_clr_idx_nxt;
      r_clr_pend <= w_clr_pend_nxt;
      if (w_accept) begin
        r_upd_addr  <= upd_addr_i;
        r_upd_taken <= upd_taken_i;
      end
    end
  end

  assign dbg_state_o = rst ? 2'd0 : r_state;

endmodule
